// File: rtl/int_timer_ctrl_if.sv
// Signal bundle between the pipeline/CP0 side and the interrupt front-end.
// Signal names match the original flat port list.
interface int_timer_ctrl_if;
  logic [5:0]  hw_int_in;
  logic [31:0] count;
  logic        cp0_wen;
  logic [4:0]  cp0_num;
  logic [2:0]  sel;
  logic [31:0] cp0_data;
  logic        pause2;
  logic [5:0]  ext_int;
  logic [31:0] compare;
  logic        ti;

  modport master (
    output hw_int_in, count, cp0_wen, cp0_num, sel, cp0_data, pause2,
    input  ext_int, compare, ti
  );

  modport slave (
    input  hw_int_in, count, cp0_wen, cp0_num, sel, cp0_data, pause2,
    output ext_int, compare, ti
  );
endinterface

// File: rtl/int_timer_ctrl.sv
// Interrupt front-end for CP0: pin synchronisers, Compare register and timer match.
// Define TIMER_INT_EN to OR the timer interrupt into ext_int[5] (IP7).
module int_timer_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [5:0]  INT_MASK    = 6'b111111
) (
  input logic             clk,
  input logic             rst,
  int_timer_ctrl_if.slave bus
);

  logic [5:0]  sync_q [SYNC_STAGES];
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;
  logic        armed_q, armed_d;
  logic        cmp_wr;
  logic        ti_gated;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.hw_int_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign cmp_wr = bus.cp0_wen && (bus.cp0_num == 5'd11) && (bus.sel == 3'd0) && !bus.pause2;

  // A Compare write takes priority over a match seen in the same cycle.
  always_comb begin
    compare_d = compare_q;
    ti_d      = ti_q;
    armed_d   = armed_q;
    if (cmp_wr) begin
      compare_d = bus.cp0_data;
      ti_d      = 1'b0;
      armed_d   = 1'b1;
    end else if (armed_q && (bus.count == compare_q)) begin
      ti_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      compare_q <= '0;
      ti_q      <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      compare_q <= compare_d;
      ti_q      <= ti_d;
      armed_q   <= armed_d;
    end
  end

`ifdef TIMER_INT_EN
  assign ti_gated = ti_q;
`else
  assign ti_gated = 1'b0;
`endif

  assign bus.ext_int[4:0] = sync_q[SYNC_STAGES-1][4:0] & INT_MASK[4:0];
  assign bus.ext_int[5]   = (sync_q[SYNC_STAGES-1][5] | ti_gated) & INT_MASK[5];
  assign bus.compare      = compare_q;
  assign bus.ti           = ti_q;

endmodule

// File: doc/int_timer_ctrl.md
Name: int_timer_ctrl

Overview:
- Interrupt front-end directly upstream of the CP0 block; produces the 6-bit `ext_int` vector that CP0 samples into Cause.IP[7:2].
- Synchronises the raw asynchronous hardware interrupt pins into the core clock domain.
- Holds the Compare register (CP0 reg 11, sel 0) and raises the timer interrupt when CP0's Count equals Compare.
- Merges the timer interrupt onto `ext_int[5]` (IP7), per MIPS32 convention.

Parameters:
- SYNC_STAGES, 2, synchroniser depth per interrupt line; legal range 2..4.
- INT_MASK, 6'b111111, static per-line enable; a 0 bit forces that `ext_int` bit to 0.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- hw_int_in  input  6  raw external interrupt lines, level-sensitive, asynchronous to clk
- count  input  32  current CP0 Count value
- cp0_wen  input  1  MTC0 commit strobe, one cycle per instruction
- cp0_num  input  5  MTC0 destination register number
- sel  input  3  MTC0 select field
- cp0_data  input  32  MTC0 write data
- pause2  input  1  pipeline stall at the CP0 stage
- ext_int  output  6  interrupt vector to CP0 Cause[15:10]
- compare  output  32  Compare register value, for CP0 read-back
- ti  output  1  timer interrupt pending (Cause.TI source)

Behaviour:
- Reset (rst=0, takes effect asynchronously, including mid-operation):
  - All synchroniser flops, `compare`, `ti` and the internal `armed` flag clear to 0.
  - `ext_int`=0.
- Synchroniser:
  - Each `hw_int_in[i]` passes through SYNC_STAGES flops.
  - A change on the pin appears on `ext_int[i]` exactly SYNC_STAGES rising edges later.
  - There is no combinational path from `hw_int_in` to any output.
- Compare write:
  - Write condition: cp0_wen=1 && cp0_num==11 && sel==0 && pause2==0.
  - On the next edge: compare<=cp0_data, ti<=0, armed<=1.
  - While pause2=1 the write is ignored; the stalled MTC0 reasserts cp0_wen when it commits.
- Timer match:
  - Set condition: armed=1 && count==compare.
  - On the next edge ti<=1. `ti` is sticky and holds until the next Compare write or reset.
  - `pause2` does not affect match detection.
  - Count advances every second clock, so a match persists for 2 cycles. Any set within those cycles yields the same single pending state.
- `armed` suppresses a spurious match at reset, when count==compare==0. There is no timer interrupt until software first writes Compare.
- Simultaneous Compare write and match in the same cycle: the write wins.
  - `ti`=0 after the edge and `compare` takes the new value.
  - The new value is matched against `count` from the following cycle onward.
- Writing a Compare value equal to the current `count`: `ti` is set on the edge after the write, provided `count` still equals it.
- Output composition, all from registered state:
  - ext_int[4:0] = sync_out[4:0] & INT_MASK[4:0]
  - ext_int[5] = (sync_out[5] | ti_gated) & INT_MASK[5]
- Writes to any other cp0_num/sel are ignored.
- `compare` is always visible on its output port.

Optional Feature:
- Macro: TIMER_INT_EN.
- Defined: ti_gated = ti; the timer interrupt is ORed into ext_int[5] as described above.
- Undefined:
  - ti_gated = 0.
  - ext_int[5] carries only the synchronised hw_int_in[5].
  - The `ti` output is still maintained so Cause.TI reads correctly, but it never raises an interrupt.

Test Plan:
1. Reset, then raise hw_int_in=6'b000100 with SYNC_STAGES=2 -> ext_int=6'b000100 exactly 2 edges later; rst=0 mid-pulse -> ext_int=0 immediately.
2. After reset with count held at 0 and no Compare write -> ti stays 0 for 100 cycles.
3. MTC0 reg 11 sel 0 with data 32'h20, then count ramps 0x1E..0x22 -> ti=1 on the edge after count==0x20; ext_int[5]=1 with TIMER_INT_EN defined; ti stays 1 after count passes 0x20.
4. With ti=1, MTC0 reg 11 with data 32'h40 in the same cycle count==0x40 -> after the edge ti=0 and compare=0x40; ti=1 on the following edge.
5. MTC0 reg 11 with pause2=1 and data 32'h99 -> compare unchanged; same write with pause2=0 -> compare=0x99.
6. INT_MASK=6'b011111, hw_int_in[5]=1 and ti=1 -> ext_int[5]=0; build without TIMER_INT_EN and ti=1 -> ext_int[5]=0 while ti output=1.
